f1_light_seq: RTL and testbench

Sequencer for the F1 start-lights game. It steps an 8-lamp light bar on a slow tick and drives the enable of the existing 4-bit LFSR, freezing it to obtain a random hold delay. It then extinguishes the lights and measures the player's reaction time in clock cycles. It sits between the clock-tick generator, the LFSR instance, the push-button input and the LED/display outputs of the lab top level.

---
 rtl/f1_light_seq.sv | 101 ++++++++++
 tb/tb_f1_light_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/f1_light_seq.sv
// F1 start-lights sequencer: steps an 8-lamp bar on a slow tick, freezes the
// external LFSR to pick a random hold delay, then times the player's reaction.
module f1_light_seq #(
    parameter int unsigned TIME_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              trigger,
    input  logic              react,
    input  logic [3:0]        lfsr_data,
    output logic              lfsr_en,
    output logic [7:0]        lights,
    output logic [TIME_W-1:0] rtime,
    output logic              rtime_valid,
    output logic              jump_start
);

    typedef enum logic [1:0] {StIdle, StSeq, StHold, StReact} state_e;

    state_e            state;
    logic              trig_q;
    logic [3:0]        delay;
    logic [TIME_W-1:0] rcount;
    logic              start;

    assign start = trigger & ~trig_q;

    // LFSR free-runs while the bar builds up and is frozen once the delay is taken.
    always_comb begin
        lfsr_en = (state == StIdle) || (state == StSeq);
    end

    // Main sequencer: priority react > tick > trigger inside each state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            trig_q      <= 1'b0;
            lights      <= 8'h00;
            delay       <= 4'd0;
            rcount      <= '0;
            rtime       <= '0;
            rtime_valid <= 1'b0;
            jump_start  <= 1'b0;
        end else begin
            trig_q      <= trigger;
            rtime_valid <= 1'b0;
            jump_start  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        lights <= 8'h01;
                        state  <= StSeq;
                    end
                end
                StSeq: begin
                    if (react) begin
                        lights     <= 8'h00;
                        jump_start <= 1'b1;
                        state      <= StIdle;
                    end else if (tick) begin
                        if (lights == 8'hFF) begin
                            // A zero LFSR value would mean no hold at all; use one tick.
                            delay <= (lfsr_data == 4'd0) ? 4'd1 : lfsr_data;
                            state <= StHold;
                        end else begin
                            lights <= {lights[6:0], 1'b1};
                        end
                    end
                end
                StHold: begin
                    if (react) begin
                        lights     <= 8'h00;
                        jump_start <= 1'b1;
                        state      <= StIdle;
                    end else if (tick) begin
                        if (delay == 4'd1) begin
                            lights <= 8'h00;
                            rcount <= '0;
                            state  <= StReact;
                        end else begin
                            delay <= delay - 4'd1;
                        end
                    end
                end
                StReact: begin
                    if (react) begin
                        rtime       <= rcount;
                        rtime_valid <= 1'b1;
                        state       <= StIdle;
                    end else if (rcount != {TIME_W{1'b1}}) begin
                        // Saturate rather than wrap so a very slow press reads as max.
                        rcount <= rcount + TIME_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_f1_light_seq.sv
// Scoreboard bench for f1_light_seq: a game-level model predicts lamp changes
// and result pulses; a monitor compares them as the DUTs present them.
module tb_f1_light_seq;

    logic        clk = 1'b0;
    logic        rst, tick, trigger, react;
    logic [3:0]  lfsr_data;
    logic        lfsr_en, lfsr_en4;
    logic [7:0]  lights, lights4;
    logic [15:0] rtime;
    logic [3:0]  rtime4;
    logic        rtime_valid, rtime_valid4, jump_start, jump_start4;

    always #5 clk = ~clk;

    f1_light_seq #(.TIME_W(16)) u_dut (
        .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .react(react),
        .lfsr_data(lfsr_data), .lfsr_en(lfsr_en), .lights(lights), .rtime(rtime),
        .rtime_valid(rtime_valid), .jump_start(jump_start)
    );

    f1_light_seq #(.TIME_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .react(react),
        .lfsr_data(lfsr_data), .lfsr_en(lfsr_en4), .lights(lights4), .rtime(rtime4),
        .rtime_valid(rtime_valid4), .jump_start(jump_start4)
    );

    typedef struct {
        bit          jmp;
        logic [15:0] rt;
        logic [3:0]  rt4;
    } ev_t;

    logic [7:0]  lq[$];
    ev_t         evq[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [7:0]  mlights = 8'h00;
    logic [15:0] last16 = 16'd0;
    logic [3:0]  last4 = 4'd0;
    bit          mon_on = 1'b0;
    logic [7:0]  prev_lights = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic bad(input string name, input logic [31:0] act);
        n_total++;
        $display("FAIL %s: got %0h, expected nothing at %0t", name, act, $time);
    endtask

    // Model: record a lamp-bar change only when the visible value differs.
    task automatic set_lights(input logic [7:0] v);
        if (v != mlights) lq.push_back(v);
        mlights = v;
    endtask

    task automatic push_ev(input bit jmp, input int n);
        ev_t e;
        e.jmp = jmp;
        if (!jmp) begin
            last16 = 16'(n);
            last4  = (n > 15) ? 4'hF : 4'(n);
        end
        e.rt  = last16;
        e.rt4 = last4;
        evq.push_back(e);
    endtask

    function automatic logic [3:0] rnd4();
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic cyc(input bit t, input bit r, input bit trg, input bit rs,
                       input logic [3:0] lf);
        tick = t; react = r; trigger = trg; rst = rs; lfsr_data = lf;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every lamp change and every result pulse with the model.
    always @(negedge clk) begin
        if (mon_on) begin
            if (lights !== prev_lights) begin
                if (lq.size() == 0) bad("lights_unexpected", 32'(lights));
                else begin
                    logic [7:0] le;
                    le = lq.pop_front();
                    chk("lights", 32'(lights), 32'(le));
                    chk("lights_w4", 32'(lights4), 32'(le));
                end
                prev_lights = lights;
            end
            if (rtime_valid | jump_start | rtime_valid4 | jump_start4) begin
                if (evq.size() == 0) bad("pulse_unexpected", {jump_start, rtime_valid});
                else begin
                    ev_t e;
                    e = evq.pop_front();
                    chk("jump_start", 32'(jump_start), 32'(e.jmp));
                    chk("rtime_valid", 32'(rtime_valid), 32'(!e.jmp));
                    chk("jump_start_w4", 32'(jump_start4), 32'(e.jmp));
                    chk("rtime_valid_w4", 32'(rtime_valid4), 32'(!e.jmp));
                    chk("rtime", 32'(rtime), 32'(e.rt));
                    chk("rtime_w4", 32'(rtime4), 32'(e.rt4));
                end
            end
        end
    end

    // mode 0: normal, react n cycles into the reaction phase
    // mode 1: react on the idle cycle just before tick jt
    // mode 2: react together with tick jt
    // mode 3: reset on the idle cycle just before tick jt
    task automatic run_game(input int p, input int lval, input int mode, input int jt,
                            input int n, input bit hold);
        int d, tot;
        bit trg;
        d   = (lval == 0) ? 1 : lval;
        tot = 8 + d;
        set_lights(8'h01);
        cyc(0, 0, 1, 0, rnd4());
        for (int i = 1; i <= tot; i++) begin
            for (int w = 0; w < p - 1; w++) begin
                trg = hold ? 1'b1 : 1'($urandom_range(0, 1));
                if (w == p - 2 && i == jt && mode == 1) begin
                    set_lights(8'h00);
                    push_ev(1, 0);
                    cyc(0, 1, trg, 0, rnd4());
                    chk("lfsr_en_after_jump", 32'(lfsr_en), 32'd1);
                    return;
                end
                if (w == p - 2 && i == jt && mode == 3) begin
                    set_lights(8'h00);
                    last16 = 16'd0;
                    last4  = 4'd0;
                    cyc(0, 0, 0, 1, rnd4());
                    chk("rst_lfsr_en", 32'(lfsr_en), 32'd1);
                    chk("rst_lights", 32'(lights), 32'd0);
                    chk("rst_rtime", 32'(rtime), 32'd0);
                    return;
                end
                cyc(0, 0, trg, 0, rnd4());
            end
            trg = hold ? 1'b1 : 1'($urandom_range(0, 1));
            if (mode == 2 && i == jt) begin
                set_lights(8'h00);
                push_ev(1, 0);
                cyc(1, 1, trg, 0, rnd4());
                chk("lfsr_en_after_jump", 32'(lfsr_en), 32'd1);
                return;
            end
            if (i <= 7) set_lights({mlights[6:0], 1'b1});
            if (i == tot) set_lights(8'h00);
            cyc(1, 0, trg, 0, (i == 8) ? 4'(lval) : rnd4());
            chk("lfsr_en_phase", 32'(lfsr_en), (i < 8) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < n; k++) begin
            trg = hold ? 1'b1 : 1'($urandom_range(0, 1));
            cyc(1'($urandom_range(0, 1)), 0, trg, 0, rnd4());
            if (k == n / 2) chk("lfsr_en_react", 32'(lfsr_en), 32'd0);
        end
        push_ev(0, n);
        cyc(0, 1, hold, 0, rnd4());
        chk("lfsr_en_done", 32'(lfsr_en), 32'd1);
    endtask

    task automatic play(input int p, input int lval, input int mode, input int jt,
                        input int n, input bit hold);
        run_game(p, lval, mode, jt, n, hold);
        if (hold && mode != 3) repeat (6) cyc(1'($urandom_range(0, 1)), 0, 1, 0, rnd4());
        repeat (2) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, rnd4());
    endtask

    initial begin
        int p, lv, md, jt, n;
        cyc(0, 0, 0, 1, 4'd0);
        cyc(0, 0, 0, 1, 4'd0);
        chk("reset_lights", 32'(lights), 32'd0);
        chk("reset_rtime", 32'(rtime), 32'd0);
        chk("reset_valid", 32'(rtime_valid), 32'd0);
        chk("reset_jump", 32'(jump_start), 32'd0);
        chk("reset_lfsr_en", 32'(lfsr_en), 32'd1);
        prev_lights = lights;
        mon_on = 1'b1;
        cyc(0, 0, 0, 0, 4'd0);

        play(10, 3, 0, 0, 25, 0);   // normal run
        play(4, 0, 0, 0, 7, 0);     // zero LFSR value -> one-tick hold
        play(3, 6, 1, 4, 0, 0);     // jump start at lights 0F
        play(3, 5, 2, 10, 0, 0);    // react and tick in same HOLD cycle
        play(3, 4, 0, 0, 30, 0);    // saturation of the narrow build
        play(3, 2, 0, 0, 5, 1);     // trigger held high across a run
        play(3, 5, 3, 10, 0, 0);    // reset mid-HOLD
        play(2, 1, 0, 0, 0, 0);     // react in first REACT cycle

        for (int g = 0; g < 40; g++) begin
            p  = $urandom_range(2, 6);
            lv = $urandom_range(0, 15);
            md = $urandom_range(0, 3);
            jt = $urandom_range(1, 8 + ((lv == 0) ? 1 : lv));
            n  = $urandom_range(0, 40);
            play(p, lv, md, jt, n, ($urandom_range(0, 3) == 0));
        end

        repeat (4) cyc(0, 0, 0, 0, rnd4());
        chk("lights_queue_drained", 32'(lq.size()), 32'd0);
        chk("event_queue_drained", 32'(evq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
